// File: rtl/multi_channel_delay_line.sv
// multi_channel_delay_line
// N_CHANNELS independent sample delay lines sharing one strobe and one
// write pointer. Each channel delays its stream by delay_i samples, in the
// range 0 .. 2^LOG2_MAX_DELAY-1. The output is forced to zero until the
// channel buffer holds enough real samples for the requested delay.
//
// Build option: define DELAY_LINE_MUTE_ON_CHANGE_EN to also mute a channel
// after its delay changes, until the buffer refills to the new delay.
module multi_channel_delay_line #(
  parameter int LOG2_MAX_DELAY = 5,
  parameter int DATA_WIDTH     = 13,
  parameter int N_CHANNELS     = 2
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [N_CHANNELS*LOG2_MAX_DELAY-1:0] delay_i,
  input  logic                               data_valid_i,
  input  logic [N_CHANNELS*DATA_WIDTH-1:0]   data_i,
  output logic [N_CHANNELS*DATA_WIDTH-1:0]   data_o,
  output logic                               data_valid_o
);

  localparam int DEPTH = 2 ** LOG2_MAX_DELAY;

  typedef logic [LOG2_MAX_DELAY-1:0] ptr_t;
  typedef logic [DATA_WIDTH-1:0]     word_t;

  localparam ptr_t CNT_MAX = '1;

  // Sample storage is never reset; validity is tracked only by cnt_q.
  word_t mem_q [N_CHANNELS][DEPTH];

  ptr_t  wp_q, wp_d;
  ptr_t  cnt_q   [N_CHANNELS];
  ptr_t  cnt_d   [N_CHANNELS];
  ptr_t  dprev_q [N_CHANNELS];
  ptr_t  dprev_d [N_CHANNELS];
  logic [N_CHANNELS*DATA_WIDTH-1:0] data_q, data_d;
  logic  valid_q;

  ptr_t  dly     [N_CHANNELS];
  ptr_t  cnt_eff [N_CHANNELS];
  ptr_t  rd_addr [N_CHANNELS];
  word_t din     [N_CHANNELS];
  word_t rd_word [N_CHANNELS];

  // Per-channel unpacking, effective fill level and read of the delayed word.
  // The read address is always behind wp, so it never aliases the write slot.
  always_comb begin
    for (int c = 0; c < N_CHANNELS; c++) begin
      dly[c]     = delay_i[c*LOG2_MAX_DELAY +: LOG2_MAX_DELAY];
      din[c]     = data_i[c*DATA_WIDTH +: DATA_WIDTH];
      rd_addr[c] = wp_q - dly[c];
      rd_word[c] = mem_q[c][rd_addr[c]];
`ifdef DELAY_LINE_MUTE_ON_CHANGE_EN
      cnt_eff[c] = (dly[c] != dprev_q[c]) ? '0 : cnt_q[c];
`else
      cnt_eff[c] = cnt_q[c];
`endif
    end
  end

  // Next-state computation; nothing moves without a strobe.
  always_comb begin
    wp_d    = wp_q;
    cnt_d   = cnt_q;
    dprev_d = dprev_q;
    data_d  = data_q;
    if (data_valid_i) begin
      wp_d = wp_q + ptr_t'(1);
      for (int c = 0; c < N_CHANNELS; c++) begin
        if (dly[c] == '0) begin
          data_d[c*DATA_WIDTH +: DATA_WIDTH] = din[c];
        end else if (cnt_eff[c] >= dly[c]) begin
          data_d[c*DATA_WIDTH +: DATA_WIDTH] = rd_word[c];
        end else begin
          data_d[c*DATA_WIDTH +: DATA_WIDTH] = '0;
        end
        cnt_d[c]   = (cnt_eff[c] == CNT_MAX) ? CNT_MAX : cnt_eff[c] + ptr_t'(1);
        dprev_d[c] = dly[c];
      end
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wp_q    <= '0;
      cnt_q   <= '{default: '0};
      dprev_q <= '{default: '0};
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      cnt_q   <= cnt_d;
      dprev_q <= dprev_d;
      data_q  <= data_d;
      valid_q <= data_valid_i;
    end
  end

  // Sample write; a strobe coinciding with reset is dropped.
  always_ff @(posedge clk_i) begin
    if (!rst_i && data_valid_i) begin
      for (int c = 0; c < N_CHANNELS; c++) begin
        mem_q[c][wp_q] <= din[c];
      end
    end
  end

  assign data_o       = data_q;
  assign data_valid_o = valid_q;

endmodule

// File: tb/tb_multi_channel_delay_line.sv
// Testbench for multi_channel_delay_line: directed scenarios plus random
// traffic, checked every cycle against a sample-history reference model.
module tb_multi_channel_delay_line;

  localparam int L  = 5;
  localparam int DW = 13;
  localparam int NC = 2;

  logic               clk_i = 1'b0;
  logic               rst_i = 1'b1;
  logic [NC*L-1:0]    delay_i = '0;
  logic               data_valid_i = 1'b0;
  logic [NC*DW-1:0]   data_i = '0;
  logic [NC*DW-1:0]   data_o;
  logic               data_valid_o;

  multi_channel_delay_line #(
    .LOG2_MAX_DELAY(L), .DATA_WIDTH(DW), .N_CHANNELS(NC)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .delay_i(delay_i),
    .data_valid_i(data_valid_i), .data_i(data_i),
    .data_o(data_o), .data_valid_o(data_valid_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: full history of written samples, plus the number of
  // strobes since the channel last became "fresh" (reset, or delay change
  // when muting on change is built in).
  logic [DW-1:0] hist0 [$];
  logic [DW-1:0] hist1 [$];
  int            run   [NC];
  int            dprev [NC];
  logic [DW-1:0] exp_d [NC];
  logic          exp_v;

  function automatic logic [DW-1:0] hist_at(input int c, input int idx);
    return (c == 0) ? hist0[idx] : hist1[idx];
  endfunction

  task automatic model(input logic rst, input logic vld, input int d[NC], input logic [DW-1:0] x[NC]);
    if (rst) begin
      hist0.delete();
      hist1.delete();
      for (int c = 0; c < NC; c++) begin
        run[c] = 0; dprev[c] = 0; exp_d[c] = '0;
      end
      exp_v = 1'b0;
    end else begin
      exp_v = vld;
      if (vld) begin
        for (int c = 0; c < NC; c++) begin
          int n;
          n = (c == 0) ? hist0.size() : hist1.size();
`ifdef DELAY_LINE_MUTE_ON_CHANGE_EN
          if (d[c] != dprev[c]) run[c] = 0;
`endif
          if (d[c] == 0)          exp_d[c] = x[c];
          else if (run[c] >= d[c]) exp_d[c] = hist_at(c, n - d[c]);
          else                    exp_d[c] = '0;
          if (c == 0) hist0.push_back(x[c]); else hist1.push_back(x[c]);
          run[c]   = run[c] + 1;
          dprev[c] = d[c];
        end
      end
    end
  endtask

  // One clock: apply inputs, advance model, compare all outputs.
  task automatic step(input logic rst, input logic vld, input int d0, input int d1,
                      input int x0, input int x1);
    int            d [NC];
    logic [DW-1:0] x [NC];
    d[0] = d0; d[1] = d1;
    x[0] = DW'(x0); x[1] = DW'(x1);
    rst_i        = rst;
    data_valid_i = vld;
    delay_i      = {L'(d1), L'(d0)};
    data_i       = {x[1], x[0]};
    @(posedge clk_i);
    #1;
    model(rst, vld, d, x);
    chk("valid", 32'(data_valid_o), 32'(exp_v));
    chk("ch0", 32'(data_o[0 +: DW]), 32'(exp_d[0]));
    chk("ch1", 32'(data_o[DW +: DW]), 32'(exp_d[1]));
  endtask

  int exp_plan [5];
  int dr0, dr1, gap;

  initial begin
    // Reset state
    step(1, 0, 0, 0, 0, 0);
    chk("rst_valid", 32'(data_valid_o), 32'd0);
    chk("rst_data", 32'(data_o), 32'd0);

    // Pass-through with delay 0
    step(0, 1, 0, 0, 100, 5);
    chk("pass_v", 32'(data_valid_o), 32'd1);
    chk("pass_ch0", 32'(data_o[0 +: DW]), 32'd100);
    chk("pass_ch1", 32'(data_o[DW +: DW]), 32'd5);
    step(0, 0, 0, 0, 0, 0);
    chk("pulse_end", 32'(data_valid_o), 32'd0);

    // Delay 3 after reset
    step(1, 0, 0, 0, 0, 0);
    exp_plan = '{0, 0, 0, 1, 2};
    for (int k = 1; k <= 5; k++) begin
      step(0, 1, 3, 0, k, k + 50);
      chk("d3_ch0", 32'(data_o[0 +: DW]), 32'(exp_plan[k-1]));
    end

    // Maximum delay with wrap-around
    step(1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 40; k++) begin
      step(0, 1, 31, 7, k, 200 + k);
      if (k == 31) chk("d31_last0", 32'(data_o[0 +: DW]), 32'd0);
      if (k == 32) chk("d31_first", 32'(data_o[0 +: DW]), 32'd1);
      if (k == 40) chk("d31_wrap", 32'(data_o[0 +: DW]), 32'd9);
    end

    // Delay change 2 -> 4 at strobe 10 on ch0 only
    step(1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 16; k++) begin
      step(0, 1, (k < 10) ? 2 : 4, 3, k, 300 + k);
`ifdef DELAY_LINE_MUTE_ON_CHANGE_EN
      if (k >= 10 && k <= 13) chk("chg_mute", 32'(data_o[0 +: DW]), 32'd0);
      if (k == 14) chk("chg_resume", 32'(data_o[0 +: DW]), 32'd10);
`else
      if (k == 10) chk("chg_old", 32'(data_o[0 +: DW]), 32'd6);
`endif
      if (k == 12) chk("chg_ch1", 32'(data_o[DW +: DW]), 32'd309);
    end

    // Reset mid-stream with strobe high
    step(1, 1, 2, 2, 55, 66);
    chk("mid_rst_v", 32'(data_valid_o), 32'd0);
    chk("mid_rst_d", 32'(data_o), 32'd0);
    step(0, 1, 2, 0, 7, 1);
    chk("r7", 32'(data_o[0 +: DW]), 32'd0);
    step(0, 1, 2, 0, 8, 2);
    chk("r8", 32'(data_o[0 +: DW]), 32'd0);
    step(0, 1, 2, 0, 9, 3);
    chk("r9", 32'(data_o[0 +: DW]), 32'd7);

    // Gaps between strobes, delay 1
    step(1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 30; k++) begin
      step(0, 1, 1, 1, 400 + k, 500 + k);
      if (k > 1) chk("gap_ch0", 32'(data_o[0 +: DW]), 32'(399 + k));
      gap = $urandom_range(0, 5);
      for (int g = 0; g < gap; g++) step(0, 0, 1, 1, $urandom, $urandom);
    end

    // Random traffic
    step(1, 0, 0, 0, 0, 0);
    dr0 = 0; dr1 = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) dr0 = $urandom_range(0, 31);
      if ($urandom_range(0, 39) == 0) dr1 = $urandom_range(0, 31);
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0),
           dr0, dr1, $urandom_range(0, 8191), $urandom_range(0, 8191));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_channel_delay_line.md
# multi_channel_delay_line

Parametrised successor to the single-channel fine delay line: delays N_CHANNELS independent sample streams by a per-channel programmable number of valid samples, from 0 to 2^LOG2_MAX_DELAY−1. Sits in the pt_feedback datapath between the ADC decimation stage and the feedback filter, and provides per-channel phase trimming. Adds two behaviours the earlier block lacks: zero-output muting until the buffer holds real data, and an optional mute after a delay change.

## Interface
- LOG2_MAX_DELAY, 5, log2 of buffer depth per channel; maximum delay is 2^LOG2_MAX_DELAY−1 samples
- DATA_WIDTH, 13, bits per sample
- N_CHANNELS, 2, number of independent channels
- clk_i  in  1  system clock; one clock; all logic rising-edge
- rst_i  in  1  reset, synchronous, active-high
- delay_i  in  N_CHANNELS*LOG2_MAX_DELAY  per-channel delay; channel c in bits [c*LOG2_MAX_DELAY +: LOG2_MAX_DELAY]
- data_valid_i  in  1  sample strobe, shared by all channels
- data_i  in  N_CHANNELS*DATA_WIDTH  packed samples; channel c in bits [c*DATA_WIDTH +: DATA_WIDTH]
- data_o  out  N_CHANNELS*DATA_WIDTH  delayed samples, packed the same way as data_i
- data_valid_o  out  1  output strobe

## Operation
- Each channel has a circular buffer of 2^LOG2_MAX_DELAY words, a shared write pointer wp (next write address), a fill counter cnt_c and a stored delay dprev_c.
- Work happens only on cycles with data_valid_i=1. Cycles without it change no state and hold data_o.
- On strobe k, with d = delay_i of channel c sampled in that same cycle:
  - Source: d==0 gives data_i (pass-through); otherwise mem[wp−d] mod 2^LOG2_MAX_DELAY, which is sample k−d. The read is taken before the write.
  - Gate: the output is the source if d==0 or cnt_eff ≥ d, otherwise 0. cnt_eff = cnt_c, except as modified under Configuration.
  - Update: write data_i to mem[wp], wp←wp+1 (wraps), cnt_c←min(cnt_eff+1, 2^LOG2_MAX_DELAY−1), dprev_c←d.
- The read address never equals the write address, because d ≤ depth−1, so there is no read/write collision.
- Delay is a pure sample count. Delay changes take effect on the first strobe after the change; there is no interpolation.
- Memory contents are not reset (BRAM-inferable). Validity comes only from cnt_c.
- Reset, including mid-operation: wp=0, all cnt_c=0, all dprev_c=0, data_o=0, data_valid_o=0, registered on the reset cycle. Any in-flight strobe is discarded. The first strobe after reset with d>0 outputs 0.

## Timing
- Latency is 1 clock: data_valid_o is high exactly in the cycle after data_valid_i is high, and data_o updates in that same cycle.
- data_valid_o is a single-cycle pulse per input strobe. Back-to-back strobes (data_valid_i held high) are supported at full rate.
- data_o is held between strobes.
- The read is registered: the memory read address is computed from wp and delay_i in the strobe cycle, and the output register captures the result.
- Maximum delay 2^LOG2_MAX_DELAY−1 (31 by default) is exact. All pointer arithmetic is modulo 2^LOG2_MAX_DELAY.

## Configuration
- DELAY_LINE_MUTE_ON_CHANGE_EN defined:
  - On a strobe where d ≠ dprev_c, cnt_eff = 0 for that channel.
  - The output is therefore 0 for the next d strobes, then real delayed data resumes.
  - Channels are muted independently.
- Not defined:
  - cnt_eff = cnt_c always. A delay change immediately outputs old buffer contents, which are real past samples once the buffer is filled.
  - The muting after reset still applies.

## Test plan
- Reset, then all delays 0, then data_i ch0=100, ch1=5 with one strobe: data_valid_o pulses 1 cycle later with ch0=100, ch1=5.
- After reset, ch0 delay=3 and strobes carry 1,2,3,4,5: ch0 outputs 0,0,0,1,2. Each data_valid_o pulse lags its strobe by exactly 1 clock.
- ch0 delay=31 with 40 strobes of values 1..40: outputs 0 for strobes 1–31, then 1..9. This checks wrap-around.
- Steady stream with ch0 delay=2 changed to 4 at strobe 10:
  - With the macro: ch0 outputs 0 for strobes 10–13, then sample 10 at strobe 14. ch1 is unaffected.
  - Without the macro: strobe 10 outputs sample 6 immediately.
- Assert rst_i mid-stream with data_valid_i high: the next cycle has data_valid_o=0 and data_o=0. Then delay=2 with strobes 7,8,9 outputs 0,0,7.
- Gaps of 0–5 idle cycles between strobes with delay=1: outputs equal the previous strobe's sample, data_o holds during gaps, and no extra data_valid_o pulses occur.
